// File: rtl/m9_edge_collector.sv
// rtl/m9_edge_collector.sv - per-channel rising-edge counters with handshaked count reports (optional M9_SYNC_EN input synchronizer)
module m9_edge_collector #(
  parameter int CNT_W  = 8,
  parameter int THRESH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in9_1,
  input  logic                 in9_2,
  input  logic                 in9_3,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*CNT_W+2:0]   out_data
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

  typedef enum logic {IDLE, REPORT} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       in_vec;
  logic [2:0]       s_q;
  logic [2:0]       p_q;
  logic [2:0]       edge_v;
  logic [CNT_W-1:0] cnt_q [3];
  logic             ovf_live_q;
  logic             flush_pend_q;
  logic             trig_thr;
  logic             trig_fl;
  logic             snap;
  logic             ovf_hit;

  assign in_vec = {in9_3, in9_2, in9_1};

`ifdef M9_SYNC_EN
  logic [2:0] meta_q;

  // Two-flop synchronizer; the second flop doubles as the sample stage s_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      s_q    <= '0;
    end else begin
      meta_q <= in_vec;
      s_q    <= meta_q;
    end
  end
`else
  // Single sample stage; inputs are assumed synchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= in_vec;
    end
  end
`endif

  // History stage; clearing it on reset makes a high input count once after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else begin
      p_q <= s_q;
    end
  end

  assign edge_v = s_q & ~p_q;

  // Report triggers, evaluated on registered (pre-increment) counts
  always_comb begin
    trig_thr = 1'b0;
    ovf_hit  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (cnt_q[i] >= THRESH_V) trig_thr = 1'b1;
      if (edge_v[i] && (cnt_q[i] == CNT_MAX)) ovf_hit = 1'b1;
    end
    trig_fl = flush_pend_q | flush;
    snap    = (state_q == IDLE) && (trig_thr || trig_fl);
  end

  // Saturating counters; a snapshot restarts each from this cycle's edge so none is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (snap) begin
          cnt_q[i] <= CNT_W'(edge_v[i]);
        end else if (edge_v[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Sticky overflow and pending-flush flags, both consumed by a snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_live_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else if (snap) begin
      ovf_live_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      if (ovf_hit) ovf_live_q   <= 1'b1;
      if (flush)   flush_pend_q <= 1'b1;
    end
  end

  // Record register, loaded only at a snapshot and held through REPORT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (snap) begin
      out_data <= {ovf_live_q, trig_fl, trig_thr, cnt_q[2], cnt_q[1], cnt_q[0]};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave REPORT only on handshake, so at least one IDLE cycle separates records
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trig_thr || trig_fl) state_d = REPORT;
      REPORT:  if (out_ready)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    out_valid = (state_q == REPORT);
  end

endmodule

// File: tb/tb_m9_edge_collector.sv
// tb/tb_m9_edge_collector.sv - scoreboard bench for m9_edge_collector (CNT_W=8, THRESH=4)
module tb_m9_edge_collector;

  localparam int CNT_W = 8;
  localparam int DW    = 3*CNT_W+3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in9_1, in9_2, in9_3;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  logic [DW-1:0] exp_q [$];
  int            n_assert = 0;
  int            n_fail   = 0;

  m9_edge_collector #(.CNT_W(CNT_W), .THRESH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in9_1     (in9_1),
    .in9_2     (in9_2),
    .in9_3     (in9_3),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic ovf, input logic [1:0] cause,
                                       input int c3, input int c2, input int c1);
    return {ovf, cause, 8'(c3), 8'(c2), 8'(c1)};
  endfunction

  // One cycle: at the negedge, score any handshake about to happen; return #1 after the posedge
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_record: got %h, none expected", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL record: got %h, expected %h", out_data, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain_timeout: %0d records outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(input int max_cyc);
    int n = 0;
    while (out_valid !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) begin
      n_assert++;
      n_fail++;
      $display("FAIL valid_timeout: out_valid %b, expected 1", out_valid);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic pulse(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      if (ch == 1) in9_1 = 1'b1; else if (ch == 2) in9_2 = 1'b1; else in9_3 = 1'b1;
      tick();
      in9_1 = 1'b0; in9_2 = 1'b0; in9_3 = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    in9_1 = 1'b1; in9_2 = 1'b1; in9_3 = 1'b1;
    flush = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b, expected 0", out_valid);
    end
    n_assert++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, expected 0", out_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    exp_q.push_back(mk(1'b0, 2'b10, 1, 1, 1));
    do_flush();
    wait_drain(20);
    in9_1 = 1'b0; in9_2 = 1'b0; in9_3 = 1'b0;
    tick();
  endtask

  task automatic test_threshold();
    exp_q.push_back(mk(1'b0, 2'b01, 0, 0, 4));
    pulse(1, 4);
    wait_drain(20);
    n_assert++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_one_cycle: got %b after handshake, expected 0", out_valid);
    end
    tick();
  endtask

  task automatic test_flush();
    exp_q.push_back(mk(1'b0, 2'b10, 0, 2, 0));
    pulse(2, 2);
    do_flush();
    wait_drain(20);
    tick();
    exp_q.push_back(mk(1'b0, 2'b10, 0, 0, 0));
    do_flush();
    wait_drain(20);
    tick();
  endtask

  task automatic test_backpressure();
    int bad  = 0;
    bit seen = 0;
    out_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 2'b01, 4, 0, 0));
    exp_q.push_back(mk(1'b1, 2'b01, 255, 0, 0));
    for (int k = 0; k < 600; k++) begin
      in9_3 = ~in9_3;
      tick();
      if (out_valid === 1'b1) seen = 1;
      if (seen && (out_valid !== 1'b1 || out_data[23:16] !== 8'd4)) bad++;
    end
    n_assert++;
    if (!seen || bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: seen=%b bad_cycles=%0d, expected seen=1 bad_cycles=0", seen, bad);
    end
    in9_3 = 1'b0;
    out_ready = 1'b1;
    wait_drain(40);
    tick();
  endtask

  task automatic test_snapshot_edges();
    out_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 2'b10, 0, 0, 0));
    exp_q.push_back(mk(1'b0, 2'b01, 0, 0, 4));
    exp_q.push_back(mk(1'b0, 2'b10, 1, 1, 1));
    do_flush();
    wait_valid(20);
    pulse(1, 4);
    out_ready = 1'b1;
    in9_1 = 1'b1; in9_2 = 1'b1; in9_3 = 1'b1;
    tick();
    tick();
    in9_1 = 1'b0; in9_2 = 1'b0; in9_3 = 1'b0;
    while (exp_q.size() > 1 && out_valid === 1'b1) tick();
    tick();
    do_flush();
    wait_drain(20);
    tick();
  endtask

  task automatic test_reset_mid_report();
    out_ready = 1'b0;
    do_flush();
    wait_valid(20);
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_valid: got %b, expected 0", out_valid);
    end
    n_assert++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset_data: got %h, expected 0", out_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    exp_q.push_back(mk(1'b0, 2'b10, 0, 0, 0));
    do_flush();
    wait_drain(20);
    tick();
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_flush();
    test_backpressure();
    test_snapshot_edges();
    test_reset_mid_report();
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d records outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
